// File: rtl/tor_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tor_switch_pkg
// Brief   : Shared types, counter width and saturating increment for the
//           loopback ToR switch.
// Revision: 1.0
// ============================================================================
package tor_switch_pkg;
    localparam int MAX_PORTS = 16;
    localparam int CNT_W     = 32;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
    typedef logic [$clog2(MAX_PORTS):0]   dest_t;
    typedef logic [CNT_W-1:0]             cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction
endpackage
`default_nettype wire

// File: rtl/tor_in_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tor_in_fifo
// Brief   : First-word-fall-through synchronous FIFO; pointers carry one
//           extra wrap bit to tell full from empty.
// Revision: 1.0
// ============================================================================
module tor_in_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_wr = i_wr && !o_full;
    assign w_do_rd = i_rd && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/loopback_tor_switch.sv
`default_nettype none
// ============================================================================
// Module  : loopback_tor_switch
// Brief   : N-port ToR emulation switch: input FIFOs, per-output round-robin
//           arbitration, LATENCY-stage output delay line, drop/fwd counters.
// Revision: 1.0
// ============================================================================
module loopback_tor_switch
    import tor_switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int LATENCY    = 1,
    parameter int ALLOW_SELF = 1,
    localparam int PW        = $clog2(NUM_PORTS) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              in_valid,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
    input  logic [NUM_PORTS-1:0][PW-1:0]      in_dest,
    output logic [NUM_PORTS-1:0]              out_valid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   drop_ovf_cnt,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   drop_dest_cnt,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   fwd_cnt
);
    localparam int FW = DATA_W + PW;

    logic [NUM_PORTS-1:0]                 w_bad;
    logic [NUM_PORTS-1:0]                 w_wr;
    logic [NUM_PORTS-1:0]                 w_full;
    logic [NUM_PORTS-1:0]                 w_empty;
    logic [NUM_PORTS-1:0]                 w_pop;
    logic [NUM_PORTS-1:0][FW-1:0]         w_head;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  w_gnt;        // [output][input]
    logic [NUM_PORTS-1:0]                 w_gnt_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0]     w_gnt_data;
    port_idx_t                            w_gnt_idx [NUM_PORTS];
    port_idx_t                            r_rr      [NUM_PORTS];

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
            cnt_t r_ovf;
            cnt_t r_dst;

            assign w_bad[i] = (dest_t'(in_dest[i]) >= dest_t'(NUM_PORTS)) ||
                              ((ALLOW_SELF == 0) && (dest_t'(in_dest[i]) == dest_t'(i)));
            // Full is judged on start-of-cycle state; a same-cycle pop never makes room.
            assign w_wr[i]  = in_valid[i] && !w_bad[i] && !w_full[i];

            tor_in_fifo #(
                .WIDTH (FW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .i_wr    (w_wr[i]),
                .i_wdata ({in_data[i], in_dest[i]}),
                .i_rd    (w_pop[i]),
                .o_rdata (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= '0;
                    r_dst <= '0;
                end else if (in_valid[i]) begin
                    if (w_bad[i])       r_dst <= sat_inc(r_dst);
                    else if (w_full[i]) r_ovf <= sat_inc(r_ovf);
                end
            end

            assign drop_ovf_cnt[i]  = r_ovf;
            assign drop_dest_cnt[i] = r_dst;
        end
    endgenerate

    always_comb begin
        int j;
        w_gnt      = '0;
        w_gnt_vld  = '0;
        w_gnt_data = '0;
        w_pop      = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_gnt_idx[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                j = int'(r_rr[o]) + k;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (i == j && !w_gnt_vld[o] && !w_empty[i] &&
                        dest_t'(w_head[i][PW-1:0]) == dest_t'(o)) begin
                        w_gnt_vld[o]  = 1'b1;
                        w_gnt[o][i]   = 1'b1;
                        w_gnt_idx[o]  = port_idx_t'(i);
                    end
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_gnt[o][i]) begin
                    w_pop[i]      = 1'b1;
                    w_gnt_data[o] = w_head[i][FW-1:PW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) r_rr[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_gnt_vld[o])
                    r_rr[o] <= (int'(w_gnt_idx[o]) == NUM_PORTS - 1) ? '0
                                                                      : w_gnt_idx[o] + port_idx_t'(1);
            end
        end
    end

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            logic [LATENCY-1:0] r_dl_vld;
            logic [DATA_W-1:0]  r_dl_data [LATENCY];
            cnt_t               r_fwd;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dl_vld <= '0;
                    for (int s = 0; s < LATENCY; s++) r_dl_data[s] <= '0;
                    r_fwd <= '0;
                end else begin
                    r_dl_vld[0]  <= w_gnt_vld[o];
                    r_dl_data[0] <= w_gnt_data[o];
                    for (int s = 1; s < LATENCY; s++) begin
                        r_dl_vld[s]  <= r_dl_vld[s-1];
                        r_dl_data[s] <= r_dl_data[s-1];
                    end
                    if (r_dl_vld[LATENCY-1]) r_fwd <= sat_inc(r_fwd);
                end
            end

            assign out_valid[o] = r_dl_vld[LATENCY-1];
            assign out_data[o]  = r_dl_data[LATENCY-1];
            assign fwd_cnt[o]   = r_fwd;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_loopback_tor_switch.sv
`default_nettype none
// ============================================================================
// Module  : tb_loopback_tor_switch
// Brief   : Directed self-checking bench for loopback_tor_switch (4 ports,
//           LATENCY=1) plus a second instance with self-forwarding disabled.
// Revision: 1.0
// ============================================================================
module tb_loopback_tor_switch;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int PW = 3;

    logic                    clk;
    logic                    reset;
    logic [NP-1:0]           in_valid;
    logic [NP-1:0][DW-1:0]   in_data;
    logic [NP-1:0][PW-1:0]   in_dest;
    logic [NP-1:0]           out_valid;
    logic [NP-1:0][DW-1:0]   out_data;
    logic [NP-1:0][31:0]     drop_ovf_cnt;
    logic [NP-1:0][31:0]     drop_dest_cnt;
    logic [NP-1:0][31:0]     fwd_cnt;

    logic [NP-1:0]           ns_valid;
    logic [NP-1:0][DW-1:0]   ns_data;
    logic [NP-1:0][PW-1:0]   ns_dest;
    logic [NP-1:0]           ns_out_valid;
    logic [NP-1:0][DW-1:0]   ns_out_data;
    logic [NP-1:0][31:0]     ns_drop_ovf_cnt;
    logic [NP-1:0][31:0]     ns_drop_dest_cnt;
    logic [NP-1:0][31:0]     ns_fwd_cnt;

    int          n_chk;
    int          n_pass;
    logic        mon_en;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    loopback_tor_switch #(
        .NUM_PORTS (NP), .DATA_W (DW), .FIFO_DEPTH (16), .LATENCY (1), .ALLOW_SELF (1)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_data (in_data), .in_dest (in_dest),
        .out_valid (out_valid), .out_data (out_data),
        .drop_ovf_cnt (drop_ovf_cnt), .drop_dest_cnt (drop_dest_cnt), .fwd_cnt (fwd_cnt)
    );

    loopback_tor_switch #(
        .NUM_PORTS (NP), .DATA_W (DW), .FIFO_DEPTH (16), .LATENCY (1), .ALLOW_SELF (0)
    ) dut_ns (
        .clk (clk), .reset (reset),
        .in_valid (ns_valid), .in_data (ns_data), .in_dest (ns_dest),
        .out_valid (ns_out_valid), .out_data (ns_out_data),
        .drop_ovf_cnt (ns_drop_ovf_cnt), .drop_dest_cnt (ns_drop_dest_cnt), .fwd_cnt (ns_fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_in();
        in_valid = '0; in_data = '0; in_dest = '0;
        ns_valid = '0; ns_data = '0; ns_dest = '0;
    endtask

    // Advance one cycle; while enabled, every output-3 delivery is matched
    // against the per-source queue of accepted packets.
    task automatic tick();
        int src;
        @(posedge clk);
        #1;
        if (mon_en && out_valid[3]) begin
            src = int'(out_data[3][31:24]);
            if (src == 0) begin
                if (q0.size() == 0) chk("ovf_extra0", 64'(out_data[3]), 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("ovf_order0", 64'(out_data[3]), 64'(q0.pop_front()));
            end else if (src == 1) begin
                if (q1.size() == 0) chk("ovf_extra1", 64'(out_data[3]), 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("ovf_order1", 64'(out_data[3]), 64'(q1.pop_front()));
            end else begin
                chk("ovf_src", 64'(src), 64'd0);
            end
        end
    endtask

    initial begin
        int seen;
        n_chk  = 0;
        n_pass = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data2", 64'(out_data[2]), 64'd0);
        chk("rst_fwd2", 64'(fwd_cnt[2]), 64'd0);
        chk("rst_ovf0", 64'(drop_ovf_cnt[0]), 64'd0);
        reset = 1'b0;
        tick();

        // single packet in0 -> out2, visible at t+2
        in_valid = 4'b0001; in_dest[0] = 3'd2; in_data[0] = 32'hA5A5_0001;
        tick(); clear_in();
        chk("t1_early", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'b0100);
        chk("t1_data", 64'(out_data[2]), 64'hA5A5_0001);
        tick();
        chk("t1_idle", 64'(out_valid), 64'd0);
        chk("t1_fwd", 64'(fwd_cnt[2]), 64'd1);

        // rr_ptr[2] now 1: in3 wins over in0
        in_valid = 4'b1001; in_dest[0] = 3'd2; in_dest[3] = 3'd2;
        in_data[0] = 32'hB000_0000; in_data[3] = 32'hB000_0003;
        tick(); clear_in(); tick();
        chk("rr2_first", 64'(out_data[2]), 64'hB000_0003);
        tick();
        chk("rr2_second", 64'(out_data[2]), 64'hB000_0000);
        chk("rr2_vld", 64'(out_valid), 64'b0100);
        tick();
        chk("rr2_fwd", 64'(fwd_cnt[2]), 64'd3);

        // all four inputs to out1 in one cycle
        in_valid = 4'b1111;
        for (int k = 0; k < NP; k++) begin
            in_dest[k] = 3'd1;
            in_data[k] = 32'hC0DE_0000 + 32'(k);
        end
        tick(); clear_in(); tick();
        for (int k = 0; k < NP; k++) begin
            chk("burst_vld", 64'(out_valid), 64'b0010);
            chk("burst_data", 64'(out_data[1]), 64'hC0DE_0000 + 64'(k));
            tick();
        end
        chk("burst_idle", 64'(out_valid), 64'd0);
        chk("burst_fwd", 64'(fwd_cnt[1]), 64'd4);

        // rr_ptr[1] wrapped to 0: in0 beats in3
        in_valid = 4'b1001; in_dest[0] = 3'd1; in_dest[3] = 3'd1;
        in_data[0] = 32'hD000_0000; in_data[3] = 32'hD000_0003;
        tick(); clear_in(); tick();
        chk("wrap_first", 64'(out_data[1]), 64'hD000_0000);
        tick();
        chk("wrap_second", 64'(out_data[1]), 64'hD000_0003);
        tick();

        // loopback to self allowed on the main instance
        in_valid = 4'b0100; in_dest[2] = 3'd2; in_data[2] = 32'hE000_0002;
        tick(); clear_in(); tick();
        chk("self_vld", 64'(out_valid), 64'b0100);
        chk("self_data", 64'(out_data[2]), 64'hE000_0002);
        tick();

        // bad destinations
        in_valid = 4'b0110; in_dest[1] = 3'd7; in_dest[2] = 3'd4;
        in_data[1] = 32'hBAD0_0001; in_data[2] = 32'hBAD0_0002;
        tick(); clear_in();
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid != '0) seen++;
            tick();
        end
        chk("bad_quiet", 64'(seen), 64'd0);
        chk("bad_cnt1", 64'(drop_dest_cnt[1]), 64'd1);
        chk("bad_cnt2", 64'(drop_dest_cnt[2]), 64'd1);
        chk("bad_ovf1", 64'(drop_ovf_cnt[1]), 64'd0);

        // self-forward disabled instance: in2->2 dropped, in1->2 delivered
        ns_valid = 4'b0110; ns_dest[1] = 3'd2; ns_dest[2] = 3'd2;
        ns_data[1] = 32'hF000_0001; ns_data[2] = 32'hF000_0002;
        tick(); clear_in(); tick();
        chk("ns_vld", 64'(ns_out_valid), 64'b0100);
        chk("ns_data", 64'(ns_out_data[2]), 64'hF000_0001);
        tick();
        chk("ns_idle", 64'(ns_out_valid), 64'd0);
        chk("ns_drop2", 64'(ns_drop_dest_cnt[2]), 64'd1);
        chk("ns_drop1", 64'(ns_drop_dest_cnt[1]), 64'd0);

        // in0 and in1 both stream to out3 for 40 cycles; FIFOs fill and
        // from cycle 30 one input drops per cycle (in1 even, in0 odd)
        mon_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            in_valid = 4'b0011;
            in_dest[0] = 3'd3; in_dest[1] = 3'd3;
            in_data[0] = {8'd0, 24'(t)};
            in_data[1] = {8'd1, 24'(t)};
            if (!(t >= 30 && (t % 2) == 1)) q0.push_back({8'd0, 24'(t)});
            if (!(t >= 30 && (t % 2) == 0)) q1.push_back({8'd1, 24'(t)});
            tick();
        end
        clear_in();
        repeat (100) tick();
        mon_en = 1'b0;
        chk("ovf_left0", 64'(q0.size()), 64'd0);
        chk("ovf_left1", 64'(q1.size()), 64'd0);
        chk("ovf_cnt0", 64'(drop_ovf_cnt[0]), 64'd5);
        chk("ovf_cnt1", 64'(drop_ovf_cnt[1]), 64'd5);
        chk("ovf_fwd3", 64'(fwd_cnt[3]), 64'd70);

        // reset with queued packets and a live delay line
        for (int t = 0; t < 3; t++) begin
            in_valid = 4'b1111;
            for (int k = 0; k < NP; k++) begin
                in_dest[k] = 3'd0;
                in_data[k] = 32'h9000_0000 + 32'(t * 16 + k);
            end
            tick();
        end
        clear_in();
        chk("pre_rst_vld", 64'(out_valid[0]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data[0]), 64'd0);
        chk("mid_rst_fwd", 64'(fwd_cnt[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid != '0) seen++;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        chk("post_rst_fwd3", 64'(fwd_cnt[3]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
